// File: rtl/calendar_pkg.sv
// Shared field widths and calendar arithmetic helpers for the calendar clock.
`timescale 1ns/1ps
package calendar_pkg;

    localparam int unsigned YEAR_W  = 12;
    localparam int unsigned MONTH_W = 4;
    localparam int unsigned DAY_W   = 5;
    localparam int unsigned HOUR_W  = 5;
    localparam int unsigned MIN_W   = 6;

    // Gregorian rule: every 4th year, except centuries not divisible by 400.
    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        logic div4;
        logic div100;
        logic div400;
        div4   = (y[1:0] == 2'd0);
        div100 = ((y % 12'd100) == 12'd0);
        div400 = ((y % 12'd400) == 12'd0);
        return div4 && (!div100 || div400);
    endfunction

    // Out-of-range months fall into the default branch and report 31.
    function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                      input logic               leap);
        logic [DAY_W-1:0] days;
        case (month)
            4'd2:                     days = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:  days = 5'd30;
            default:                  days = 5'd31;
        endcase
        return days;
    endfunction

endpackage

// File: rtl/calendar_clock_prescaler.sv
// Divides the board clock into a one-cycle tick every DIV_CONST cycles.
`timescale 1ns/1ps
module clock_prescaler #(
    parameter logic [31:0] DIV_CONST = 32'd3_000_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        tick    = (count_q == DIV_CONST - 32'd1);
        count_d = tick ? '0 : count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/calendar_clock.sv
// Free-running minute/hour/day/month/year counter advanced by a prescaled tick.
`timescale 1ns/1ps
module calendar_clock
    import calendar_pkg::*;
#(
    parameter logic [31:0] DIV_CONST  = 32'd3_000_000_000,
    parameter logic [11:0] START_YEAR = 12'd2000
) (
    input  logic        MAX10_CLK1_50,
    input  logic        KEY,
    output logic [11:0] out_year,
    output logic [3:0]  out_month,
    output logic [4:0]  out_day,
    output logic [4:0]  out_hour,
    output logic [5:0]  out_min
);

    logic               tick;
    logic               leap;
    logic [DAY_W-1:0]   dim;

    logic [YEAR_W-1:0]  year_q,  year_d;
    logic [MONTH_W-1:0] month_q, month_d;
    logic [DAY_W-1:0]   day_q,   day_d;
    logic [HOUR_W-1:0]  hour_q,  hour_d;
    logic [MIN_W-1:0]   min_q,   min_d;

    clock_prescaler #(.DIV_CONST(DIV_CONST)) u_prescaler (
        .clk   (MAX10_CLK1_50),
        .rst_n (KEY),
        .tick  (tick)
    );

    // Nested carries let a year-end rollover update every field on one edge.
    always_comb begin
        leap    = is_leap(year_q);
        dim     = days_in_month(month_q, leap);
        year_d  = year_q;
        month_d = month_q;
        day_d   = day_q;
        hour_d  = hour_q;
        min_d   = min_q;
        if (tick) begin
            if (min_q < 6'd59) begin
                min_d = min_q + 6'd1;
            end else begin
                min_d = '0;
                if (hour_q < 5'd23) begin
                    hour_d = hour_q + 5'd1;
                end else begin
                    hour_d = '0;
                    if (day_q < dim) begin
                        day_d = day_q + 5'd1;
                    end else begin
                        day_d = 5'd1;
                        if (month_q < 4'd12) begin
                            month_d = month_q + 4'd1;
                        end else begin
                            month_d = 4'd1;
                            year_d  = year_q + 12'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge KEY) begin
        if (!KEY) begin
            year_q  <= START_YEAR;
            month_q <= 4'd1;
            day_q   <= 5'd1;
            hour_q  <= '0;
            min_q   <= '0;
        end else begin
            year_q  <= year_d;
            month_q <= month_d;
            day_q   <= day_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
        end
    end

    assign out_year  = year_q;
    assign out_month = month_q;
    assign out_day   = day_q;
    assign out_hour  = hour_q;
    assign out_min   = min_q;

endmodule

// File: tb/tb_calendar_clock.sv
// Directed bench for calendar_clock with a 10-cycle minute (one minute per 20 ns).
`timescale 1ns/1ps
module tb_calendar_clock;

    logic        clk;
    logic        KEY;
    logic [11:0] out_year;
    logic [3:0]  out_month;
    logic [4:0]  out_day;
    logic [4:0]  out_hour;
    logic [5:0]  out_min;

    int vectors     = 0;
    int miscompares = 0;

    logic [11:0] pl_year;
    logic [3:0]  pl_month;
    logic [4:0]  pl_day;
    logic [4:0]  pl_hour;
    logic [5:0]  pl_min;

    typedef struct {
        logic [31:0] start;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [15];

    calendar_clock #(
        .DIV_CONST  (32'd10),
        .START_YEAR (12'd2000)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .KEY           (KEY),
        .out_year      (out_year),
        .out_month     (out_month),
        .out_day       (out_day),
        .out_hour      (out_hour),
        .out_min       (out_min)
    );

    initial clk = 1'b1;
    always #1 clk = ~clk;

    function automatic logic [31:0] dt(input int y, input int mo, input int d,
                                       input int h, input int mi);
        return {12'(y), 4'(mo), 5'(d), 5'(h), 6'(mi)};
    endfunction

    task automatic check(input string name, input logic [31:0] exp);
        logic [31:0] got;
        got = {out_year, out_month, out_day, out_hour, out_min};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d-%0d-%0d %0d:%0d, want %0d-%0d-%0d %0d:%0d",
                     name, got[31:20], got[19:16], got[15:11], got[10:6], got[5:0],
                     exp[31:20], exp[19:16], exp[15:11], exp[10:6], exp[5:0]);
        end
    endtask

    // Reset, release on a falling edge, then override the counter state across
    // the first rising edge; on return the prescaler sits at 1.
    task preload(input logic [31:0] s);
        @(negedge clk);
        KEY = 1'b0;
        @(negedge clk);
        KEY = 1'b1;
        #0.5;
        pl_year  = s[31:20];
        pl_month = s[19:16];
        pl_day   = s[15:11];
        pl_hour  = s[10:6];
        pl_min   = s[5:0];
        force dut.year_q  = pl_year;
        force dut.month_q = pl_month;
        force dut.day_q   = pl_day;
        force dut.hour_q  = pl_hour;
        force dut.min_q   = pl_min;
        @(negedge clk);
        release dut.year_q;
        release dut.month_q;
        release dut.day_q;
        release dut.hour_q;
        release dut.min_q;
    endtask

    initial begin
        vecs[0]  = '{dt(2000, 2, 28, 23, 59), dt(2000, 2, 29, 0, 0)};
        vecs[1]  = '{dt(2000, 2, 29, 23, 59), dt(2000, 3, 1, 0, 0)};
        vecs[2]  = '{dt(1900, 2, 28, 23, 59), dt(1900, 3, 1, 0, 0)};
        vecs[3]  = '{dt(2023, 12, 31, 23, 59), dt(2024, 1, 1, 0, 0)};
        vecs[4]  = '{dt(2001, 4, 30, 23, 59), dt(2001, 5, 1, 0, 0)};
        vecs[5]  = '{dt(4095, 12, 31, 23, 59), dt(0, 1, 1, 0, 0)};
        vecs[6]  = '{dt(2024, 2, 28, 23, 59), dt(2024, 2, 29, 0, 0)};
        vecs[7]  = '{dt(2023, 2, 28, 23, 59), dt(2023, 3, 1, 0, 0)};
        vecs[8]  = '{dt(2000, 1, 1, 10, 59), dt(2000, 1, 1, 11, 0)};
        vecs[9]  = '{dt(2000, 1, 31, 23, 59), dt(2000, 2, 1, 0, 0)};
        vecs[10] = '{dt(2000, 6, 15, 12, 34), dt(2000, 6, 15, 12, 35)};
        vecs[11] = '{dt(2000, 11, 30, 23, 59), dt(2000, 12, 1, 0, 0)};
        vecs[12] = '{dt(2400, 2, 28, 23, 59), dt(2400, 2, 29, 0, 0)};
        vecs[13] = '{dt(2100, 2, 28, 23, 59), dt(2100, 3, 1, 0, 0)};
        vecs[14] = '{dt(2000, 9, 29, 23, 59), dt(2000, 9, 30, 0, 0)};

        // Power-on reset, first tick timing and free run
        KEY = 1'b0;
        #1.5;
        check("reset_values", dt(2000, 1, 1, 0, 0));
        #1.5;
        KEY = 1'b1;
        #0.5;
        repeat (9) @(negedge clk);
        check("before_first_tick", dt(2000, 1, 1, 0, 0));
        @(negedge clk);
        check("first_tick", dt(2000, 1, 1, 0, 1));
        repeat (4990) @(negedge clk);
        check("free_run_500", dt(2000, 1, 1, 8, 20));

        foreach (vecs[i]) begin
            preload(vecs[i].start);
            repeat (8) @(negedge clk);
            check($sformatf("hold_%0d", i), vecs[i].start);
            @(negedge clk);
            check($sformatf("vec_%0d", i), vecs[i].exp);
        end

        // A full leap day elapses into March
        preload(dt(2000, 2, 28, 23, 59));
        repeat (9) @(negedge clk);
        check("leap_day_entry", dt(2000, 2, 29, 0, 0));
        repeat (14400) @(negedge clk);
        check("leap_day_exit", dt(2000, 3, 1, 0, 0));

        // Asynchronous reset mid-count, between clock edges
        preload(dt(2023, 7, 14, 13, 37));
        repeat (9) @(negedge clk);
        check("pre_async", dt(2023, 7, 14, 13, 38));
        repeat (5) @(negedge clk);
        #0.5;
        KEY = 1'b0;
        #0.3;
        check("async_reset", dt(2000, 1, 1, 0, 0));
        @(negedge clk);
        @(negedge clk);
        check("reset_hold", dt(2000, 1, 1, 0, 0));
        KEY = 1'b1;
        #0.5;
        repeat (9) @(negedge clk);
        check("post_release_9", dt(2000, 1, 1, 0, 0));
        @(negedge clk);
        check("post_release_10", dt(2000, 1, 1, 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
